dwt_level_pack: RTL

Parametrised single-level DWT analysis stage. It generalises the fixed second-level stage to any sample width, coefficient width, tap count and output packing factor. It adds ready/valid backpressure, frame delimiting and flushing of partial words. It takes one sample per accepted beat, runs low-pass and high-pass FIR filters, downsamples by 2, and packs PACK decimated results per output word. Levels cascade by feeding lane-serialised `lo` output into the next instance.

---
 rtl/dwt_level_pack.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/dwt_level_pack.sv
// dwt_level_pack: one DWT analysis level (lo/hi FIR, decimate by 2, pack PACK results per output word)
//   clk, rstn            clock, asynchronous active-low reset
//   lo_coef, hi_coef     TAPS signed CW-bit coefficients, c[k] at [k*CW +: CW]
//   in_valid/in_ready    sample handshake; in_data sample, in_last ends the frame
//   out_valid/out_ready  word handshake; lo_data/hi_data packed lanes (lane 0 oldest)
//   out_count, out_last  valid lanes in the word, word closes a frame
module dwt_level_pack #(
    parameter int DW   = 25,
    parameter int CW   = 9,
    parameter int TAPS = 8,
    parameter int PACK = 6,
    parameter int OW   = DW + CW + $clog2(TAPS)
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic [TAPS*CW-1:0]        lo_coef,
    input  logic [TAPS*CW-1:0]        hi_coef,
    input  logic                      in_valid,
    output logic                      in_ready,
    input  logic [DW-1:0]             in_data,
    input  logic                      in_last,
    output logic                      out_valid,
    input  logic                      out_ready,
    output logic [PACK*OW-1:0]        lo_data,
    output logic [PACK*OW-1:0]        hi_data,
    output logic [$clog2(PACK+1)-1:0] out_count,
    output logic                      out_last
);
    localparam int NW = $clog2(PACK+1);

    typedef enum logic [1:0] {RUN, PAD, FLUSH} state_t;

    state_t                state_q, state_d;
    logic signed [DW-1:0]  x_q [TAPS];
    logic signed [DW-1:0]  x_d [TAPS];
    logic signed [DW-1:0]  xn [TAPS];
    logic                  par_q, par_d;
    logic                  mac_v_q, mac_v_d;
    logic signed [OW-1:0]  mac_lo_q, mac_lo_d, mac_hi_q, mac_hi_d;
    logic signed [OW-1:0]  acc_lo_q [PACK];
    logic signed [OW-1:0]  acc_lo_d [PACK];
    logic signed [OW-1:0]  acc_hi_q [PACK];
    logic signed [OW-1:0]  acc_hi_d [PACK];
    logic [NW-1:0]         acc_cnt_q, acc_cnt_d, base_cnt;
    logic                  out_valid_q, out_valid_d;
    logic [PACK*OW-1:0]    lo_out_q, lo_out_d, hi_out_q, hi_out_d, lo_pk, hi_pk;
    logic [NW-1:0]         out_cnt_q, out_cnt_d;
    logic                  out_last_q, out_last_d;
    logic                  out_free, run_ok, accept, acc_full;
    logic                  pad_go, flush_go, full_go, xfer, shift;
    logic signed [OW-1:0]  lo_sum, hi_sum, xe, lce, hce;

    always_comb begin
        out_free = !out_valid_q || out_ready;
        run_ok   = state_q == RUN && out_free;
        in_ready = rstn && run_ok;
        accept   = in_valid && run_ok;
        acc_full = acc_cnt_q == NW'(PACK);
        // PAD must not land its pair on a full accumulator that cannot drain yet
        pad_go   = state_q == PAD && !(acc_full && !out_free);
        // the frame's last pair is still in the MAC register until mac_v_q drops
        flush_go = state_q == FLUSH && !mac_v_q && out_free;
        full_go  = state_q != FLUSH && acc_full && out_free;
        xfer     = full_go || flush_go;
        shift    = accept || pad_go;
        xn[0]    = accept ? $signed(in_data) : '0;
        for (int k = 1; k < TAPS; k++) xn[k] = x_q[k-1];
        lo_sum = '0;
        hi_sum = '0;
        xe     = '0;
        lce    = '0;
        hce    = '0;
        for (int k = 0; k < TAPS; k++) begin
            xe     = OW'(xn[k]);
            lce    = OW'($signed(lo_coef[k*CW +: CW]));
            hce    = OW'($signed(hi_coef[k*CW +: CW]));
            lo_sum = lo_sum + xe * lce;
            hi_sum = hi_sum + xe * hce;
        end
        for (int k = 0; k < TAPS; k++) x_d[k] = flush_go ? '0 : shift ? xn[k] : x_q[k];
        state_d  = (accept && in_last) ? (par_q ? FLUSH : PAD) :
                   pad_go ? FLUSH : flush_go ? RUN : state_q;
        par_d    = flush_go ? 1'b0 : accept ? (in_last ? 1'b0 : !par_q) : par_q;
        mac_v_d  = (accept && par_q) || pad_go;
        mac_lo_d = mac_v_d ? lo_sum : mac_lo_q;
        mac_hi_d = mac_v_d ? hi_sum : mac_hi_q;
        // a landing pair goes to lane 0 when the accumulator empties on the same edge
        base_cnt  = xfer ? '0 : acc_cnt_q;
        acc_cnt_d = base_cnt + NW'(mac_v_q);
        lo_pk     = '0;
        hi_pk     = '0;
        for (int i = 0; i < PACK; i++) begin
            acc_lo_d[i] = (mac_v_q && base_cnt == NW'(i)) ? mac_lo_q : xfer ? '0 : acc_lo_q[i];
            acc_hi_d[i] = (mac_v_q && base_cnt == NW'(i)) ? mac_hi_q : xfer ? '0 : acc_hi_q[i];
            lo_pk[i*OW +: OW] = acc_lo_q[i];
            hi_pk[i*OW +: OW] = acc_hi_q[i];
        end
        out_valid_d = xfer || (out_valid_q && !out_ready);
        lo_out_d    = xfer ? lo_pk : lo_out_q;
        hi_out_d    = xfer ? hi_pk : hi_out_q;
        out_cnt_d   = xfer ? acc_cnt_q : out_cnt_q;
        out_last_d  = xfer ? flush_go : out_last_q;
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q     <= RUN;
            for (int k = 0; k < TAPS; k++) x_q[k] <= '0;
            par_q       <= 1'b0;
            mac_v_q     <= 1'b0;
            mac_lo_q    <= '0;
            mac_hi_q    <= '0;
            for (int i = 0; i < PACK; i++) begin
                acc_lo_q[i] <= '0;
                acc_hi_q[i] <= '0;
            end
            acc_cnt_q   <= '0;
            out_valid_q <= 1'b0;
            lo_out_q    <= '0;
            hi_out_q    <= '0;
            out_cnt_q   <= '0;
            out_last_q  <= 1'b0;
        end else begin
            state_q     <= state_d;
            x_q         <= x_d;
            par_q       <= par_d;
            mac_v_q     <= mac_v_d;
            mac_lo_q    <= mac_lo_d;
            mac_hi_q    <= mac_hi_d;
            acc_lo_q    <= acc_lo_d;
            acc_hi_q    <= acc_hi_d;
            acc_cnt_q   <= acc_cnt_d;
            out_valid_q <= out_valid_d;
            lo_out_q    <= lo_out_d;
            hi_out_q    <= hi_out_d;
            out_cnt_q   <= out_cnt_d;
            out_last_q  <= out_last_d;
        end
    end

    assign out_valid = out_valid_q;
    assign lo_data   = lo_out_q;
    assign hi_data   = hi_out_q;
    assign out_count = out_cnt_q;
    assign out_last  = out_last_q;
endmodule
